trigger_network_sync: RTL

- Network-level counterpart of the per-actor trigger FSMs.
- Consumes every trigger's sleep, sync_sleep, waited and idle/done status. Produces the broadcast all_sleep, all_sync_sleep and all_waited that the triggers consume.
- Drives the common trigger start and owns the top-level ap_start/ap_done handshake for one dataflow network invocation.

---
 rtl/trigger_network_sync_if.sv | 46 ++++
 rtl/trigger_network_sync.sv | 126 ++++++++++++
 2 files changed

// File: rtl/trigger_network_sync_if.sv
`default_nettype none
// =============================================================================
// Module   : trigger_network_sync_if
// Purpose  : ap_* handshake, per-trigger status and broadcast bundle of
//            trigger_network_sync; TRIGGER_NETWORK_CYCLE_COUNT_EN adds run_cycles.
// Revision : 1.0
// =============================================================================
interface trigger_network_sync_if #(
  parameter int NUM_ACTORS = 4
);
  logic                  ap_start;
  logic                  ap_done;
  logic                  ap_idle;
  logic                  ap_ready;
  logic [NUM_ACTORS-1:0] trig_sleep;
  logic [NUM_ACTORS-1:0] trig_sync_sleep;
  logic [NUM_ACTORS-1:0] trig_waited;
  logic [NUM_ACTORS-1:0] trig_idle;
  logic [NUM_ACTORS-1:0] trig_done;
  logic                  trig_start;
  logic                  all_sleep;
  logic                  all_sync_sleep;
  logic                  all_waited;
`ifdef TRIGGER_NETWORK_CYCLE_COUNT_EN
  logic [31:0]           run_cycles;
`endif

  // The network sync block itself.
  modport slave (
    input  ap_start, trig_sleep, trig_sync_sleep, trig_waited, trig_idle, trig_done,
`ifdef TRIGGER_NETWORK_CYCLE_COUNT_EN
    output run_cycles,
`endif
    output ap_done, ap_idle, ap_ready, trig_start, all_sleep, all_sync_sleep, all_waited
  );

  // The host plus the attached triggers.
  modport master (
    output ap_start, trig_sleep, trig_sync_sleep, trig_waited, trig_idle, trig_done,
`ifdef TRIGGER_NETWORK_CYCLE_COUNT_EN
    input  run_cycles,
`endif
    input  ap_done, ap_idle, ap_ready, trig_start, all_sleep, all_sync_sleep, all_waited
  );
endinterface
`default_nettype wire

// File: rtl/trigger_network_sync.sv
`default_nettype none
// =============================================================================
// Module   : trigger_network_sync
// Purpose  : Network-level start/done sequencer and sleep/sync/wait broadcast
//            for the per-actor trigger FSMs. Macro TRIGGER_NETWORK_CYCLE_COUNT_EN
//            adds a saturating START+RUN cycle counter (run_cycles).
// Revision : 1.0
// =============================================================================
module trigger_network_sync #(
  parameter int NUM_ACTORS = 4
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst_n,
  trigger_network_sync_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_ACTORS-1:0] started_mask_q, started_mask_d;
  logic                  trig_start_q, trig_start_d;
  logic                  ap_done_q, ap_done_d;
  logic                  ap_idle_q, ap_idle_d;
  logic                  red_sleep_q, red_sleep_d;
  logic                  red_sync_q, red_sync_d;
  logic                  red_wait_q, red_wait_d;
`ifdef TRIGGER_NETWORK_CYCLE_COUNT_EN
  localparam logic [31:0] C_RUN_CYCLES_MAX = 32'hFFFF_FFFF;
  logic [31:0]           run_cycles_q, run_cycles_d;
`endif

  always_comb begin
    state_d        = state_q;
    started_mask_d = started_mask_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ap_start) state_d = S_START;
      end
      S_START: begin
        // A trigger that already left idle and then finished must still count.
        started_mask_d = started_mask_q | ~bus.trig_idle;
        if (&started_mask_d) state_d = S_RUN;
      end
      S_RUN: begin
        if (&bus.trig_done) state_d = S_DONE;
      end
      S_DONE: begin
        started_mask_d = '0;
        state_d        = S_IDLE;
      end
      default: begin
        started_mask_d = '0;
        state_d        = S_IDLE;
      end
    endcase

    trig_start_d = (state_d == S_START);
    ap_done_d    = (state_d == S_DONE);
    ap_idle_d    = (state_d == S_IDLE);

    red_sleep_d  = &bus.trig_sleep;
    red_sync_d   = &bus.trig_sync_sleep;
    red_wait_d   = &bus.trig_waited;
  end

`ifdef TRIGGER_NETWORK_CYCLE_COUNT_EN
  always_comb begin
    run_cycles_d = run_cycles_q;
    if ((state_q == S_IDLE) && bus.ap_start) begin
      run_cycles_d = '0;
    end else if (((state_q == S_START) || (state_q == S_RUN)) &&
                 (run_cycles_q != C_RUN_CYCLES_MAX)) begin
      run_cycles_d = run_cycles_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q        <= S_IDLE;
      started_mask_q <= '0;
      trig_start_q   <= 1'b0;
      ap_done_q      <= 1'b0;
      ap_idle_q      <= 1'b1;
      red_sleep_q    <= 1'b0;
      red_sync_q     <= 1'b0;
      red_wait_q     <= 1'b0;
`ifdef TRIGGER_NETWORK_CYCLE_COUNT_EN
      run_cycles_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      started_mask_q <= started_mask_d;
      trig_start_q   <= trig_start_d;
      ap_done_q      <= ap_done_d;
      ap_idle_q      <= ap_idle_d;
      red_sleep_q    <= red_sleep_d;
      red_sync_q     <= red_sync_d;
      red_wait_q     <= red_wait_d;
`ifdef TRIGGER_NETWORK_CYCLE_COUNT_EN
      run_cycles_q   <= run_cycles_d;
`endif
    end
  end

  assign bus.trig_start = trig_start_q;
  assign bus.ap_done    = ap_done_q;
  assign bus.ap_ready   = ap_done_q;
  assign bus.ap_idle    = ap_idle_q;

  // Gated by the registered state so nothing can leave sleep before RUN.
  assign bus.all_sleep      = red_sleep_q & (state_q == S_RUN);
  assign bus.all_sync_sleep = red_sync_q  & (state_q == S_RUN);
  assign bus.all_waited     = red_wait_q  & (state_q == S_RUN);

`ifdef TRIGGER_NETWORK_CYCLE_COUNT_EN
  assign bus.run_cycles = run_cycles_q;
`endif

endmodule
`default_nettype wire
